// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared encodings and shadow-slot type for the miniRV hazard unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b11;
    localparam logic [1:0] WD_SEL_LOAD = 2'b01;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } hz_slot_t;

    // x0 is hard-wired zero, so it never participates in a dependency.
    function automatic logic slot_match(input logic re, input logic [4:0] rs,
                                        input hz_slot_t s);
        return re && s.valid && s.we && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_match.sv
// ============================================================================
// Module      : hazard_fwd_match
// Description : Forward-select and load-hit evaluation for one source operand.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_match
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       re,
    input  logic [4:0] rs,
    input  hz_slot_t   ex_slot,
    input  hz_slot_t   mem_slot,
    input  hz_slot_t   wb_slot,
    output logic [1:0] sel,
    output logic       ex_load_hit
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_ex  = slot_match(re, rs, ex_slot);
    assign w_hit_mem = slot_match(re, rs, mem_slot);
    assign w_hit_wb  = slot_match(re, rs, wb_slot);

    // Youngest producer wins.
    always_comb begin
        sel = FWD_RF;
        if (w_hit_ex) begin
            sel = FWD_EX;
        end else if (w_hit_mem) begin
            sel = FWD_MEM;
        end else if (w_hit_wb) begin
            sel = FWD_WB;
        end
    end

    assign ex_load_hit = w_hit_ex && ex_slot.is_load;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Forwarding, load-use stall and redirect flush control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic [1:0]       id_wd_sel,
    input  logic             ex_redirect,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_slot_t r_ex;
    hz_slot_t r_mem;
    hz_slot_t r_wb;
    hz_slot_t w_new;

    logic w_load_hit1;
    logic w_load_hit2;
    logic w_load_use;
    logic w_stall;

    hazard_fwd_match u_match1 (
        .re          (id_re1),
        .rs          (id_rs1),
        .ex_slot     (r_ex),
        .mem_slot    (r_mem),
        .wb_slot     (r_wb),
        .sel         (fwd1_sel),
        .ex_load_hit (w_load_hit1)
    );

    hazard_fwd_match u_match2 (
        .re          (id_re2),
        .rs          (id_rs2),
        .ex_slot     (r_ex),
        .mem_slot    (r_mem),
        .wb_slot     (r_wb),
        .sel         (fwd2_sel),
        .ex_load_hit (w_load_hit2)
    );

    // A redirect makes the ID instruction wrong-path, so its hazard is moot.
    assign w_load_use = id_valid && (w_load_hit1 || w_load_hit2);
    assign w_stall    = w_load_use && !ex_redirect;

    assign pc_stall   = w_stall;
    assign ifid_stall = w_stall;
    assign ifid_flush = ex_redirect;
    assign idex_flush = w_stall || ex_redirect;

    always_comb begin
        w_new         = '0;
        w_new.valid   = id_valid;
        w_new.rd      = id_rd;
        w_new.we      = id_rf_we;
        w_new.is_load = (id_wd_sel == WD_SEL_LOAD);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= idex_flush ? hz_slot_t'('0) : w_new;
            if (w_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_redirect) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Vector-table bench with expected-result queue for the hazard unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             cpu_clk = 1'b0;
    logic             cpu_rst;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_re1;
    logic             id_re2;
    logic [4:0]       id_rd;
    logic             id_rf_we;
    logic [1:0]       id_wd_sel;
    logic             ex_redirect;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd1_sel;
    logic [1:0]       fwd2_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_re1      (id_re1),
        .id_re2      (id_re2),
        .id_rd       (id_rd),
        .id_rf_we    (id_rf_we),
        .id_wd_sel   (id_wd_sel),
        .ex_redirect (ex_redirect),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .fwd1_sel    (fwd1_sel),
        .fwd2_sel    (fwd2_sel),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       re1;
        logic       re2;
        logic [4:0] rd;
        logic       we;
        logic [1:0] wd;
        logic       rdr;
        logic       st;
        logic       fl;
        logic [1:0] f1;
        logic [1:0] f2;
    } vec_t;

    vec_t             vecs[$];
    vec_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] m_scnt = '0;
    logic [CNT_W-1:0] m_fcnt = '0;

    function automatic void add(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic re1, input logic re2, input logic [4:0] rd,
                                input logic we, input logic [1:0] wd, input logic rdr,
                                input logic st, input logic fl, input logic [1:0] f1,
                                input logic [1:0] f2);
        vec_t e;
        e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.re1 = re1; e.re2 = re2; e.rd = rd;
        e.we = we; e.wd = wd; e.rdr = rdr; e.st = st; e.fl = fl; e.f1 = f1; e.f2 = f2;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t e);
        id_valid    = e.v;
        id_rs1      = e.rs1;
        id_rs2      = e.rs2;
        id_re1      = e.re1;
        id_re2      = e.re2;
        id_rd       = e.rd;
        id_rf_we    = e.we;
        id_wd_sel   = e.wd;
        ex_redirect = e.rdr;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge cpu_clk);
        e = exp_q.pop_front();
        chk("pc_stall",   idx, 32'(pc_stall),   32'(e.st));
        chk("ifid_stall", idx, 32'(ifid_stall), 32'(e.st));
        chk("ifid_flush", idx, 32'(ifid_flush), 32'(e.fl));
        chk("idex_flush", idx, 32'(idex_flush), 32'(e.st | e.fl));
        chk("fwd1_sel",   idx, 32'(fwd1_sel),   32'(e.f1));
        chk("fwd2_sel",   idx, 32'(fwd2_sel),   32'(e.f2));
        chk("stall_cnt",  idx, 32'(stall_cnt),  32'(m_scnt));
        chk("flush_cnt",  idx, 32'(flush_cnt),  32'(m_fcnt));
        @(posedge cpu_clk);
        #1;
        if (e.st) m_scnt = m_scnt + 1'b1;
        if (e.fl) m_fcnt = m_fcnt + 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pc_stall"},   0, 32'(pc_stall),   0);
        chk({name, "_ifid_stall"}, 0, 32'(ifid_stall), 0);
        chk({name, "_ifid_flush"}, 0, 32'(ifid_flush), 0);
        chk({name, "_idex_flush"}, 0, 32'(idex_flush), 0);
        chk({name, "_fwd1"},       0, 32'(fwd1_sel),   0);
        chk({name, "_fwd2"},       0, 32'(fwd2_sel),   0);
        chk({name, "_stall_cnt"},  0, 32'(stall_cnt),  0);
        chk({name, "_flush_cnt"},  0, 32'(flush_cnt),  0);
    endtask

    initial begin
        vec_t z;
        //   v rs1 rs2 re1 re2 rd we wd rdr | st fl f1 f2
        add(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0);   // add x5
        add(1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 0, 1, 1);   // add x6,x5,x5 : EX fwd
        add(1, 5, 6, 1, 1, 11, 1, 0, 0, 0, 0, 2, 1);   // x5 in MEM, x6 in EX
        add(1, 5, 6, 1, 1, 0, 0, 0, 0,  0, 0, 3, 2);   // x5 in WB, x6 in MEM
        add(1, 2, 0, 1, 0, 7, 1, 1, 0,  0, 0, 0, 0);   // lw x7
        add(1, 7, 0, 1, 0, 8, 1, 0, 0,  1, 0, 1, 0);   // addi x8,x7 : stall
        add(1, 7, 0, 1, 0, 8, 1, 0, 0,  0, 0, 2, 0);   // replay : MEM fwd
        add(1, 1, 0, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0);   // lw x0
        add(1, 0, 0, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0);   // add x1,x0,x0 : nothing
        add(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0);   // lui x9
        add(1, 9, 9, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0);   // jal, rs fields unused
        add(1, 2, 0, 1, 0, 3, 1, 1, 0,  0, 0, 0, 0);   // lw x3
        add(1, 3, 3, 1, 1, 4, 1, 0, 1,  0, 1, 1, 1);   // redirect beats load-use
        add(1, 3, 1, 1, 1, 5, 1, 0, 1,  0, 1, 2, 3);   // back-to-back redirect
        add(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0);   // x5 writers x3
        add(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0);
        add(1, 5, 5, 1, 1, 20, 1, 0, 0, 0, 0, 1, 1);   // x5 in all slots : EX wins
        add(1, 0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);   // lw x7
        add(0, 7, 0, 1, 0, 8, 1, 0, 0,  0, 0, 1, 0);   // invalid ID : no stall
        add(1, 7, 0, 1, 0, 8, 1, 0, 0,  0, 0, 2, 0);
        for (int k = 0; k < 16; k++) begin              // drives stall_cnt through wrap
            add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
            add(1, 7, 0, 1, 0, 8, 1, 0, 0, 1, 0, 1, 0);
            add(1, 7, 0, 1, 0, 8, 1, 0, 0, 0, 0, 2, 0);
        end

        cpu_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            id_valid    = 1'($urandom);
            id_rs1      = 5'($urandom);
            id_rs2      = 5'($urandom);
            id_re1      = 1'($urandom);
            id_re2      = 1'($urandom);
            id_rd       = 5'($urandom);
            id_rf_we    = 1'($urandom);
            id_wd_sel   = 2'($urandom);
            ex_redirect = 1'($urandom);
            @(posedge cpu_clk);
            #1;
        end
        cpu_rst = 1'b0;
        z = '{default: '0};
        drive(z);
        @(negedge cpu_clk);
        chk_all_zero("reset");
        @(posedge cpu_clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end
        chk("wrap_stall_cnt", 0, 32'(stall_cnt), 32'd1);
        chk("final_flush_cnt", 0, 32'(flush_cnt), 32'd2);

        // Reset landing on a stall cycle drops the stall.
        apply(vecs[vecs.size() - 3], 900);
        drive(vecs[vecs.size() - 2]);
        @(negedge cpu_clk);
        chk("pre_rst_stall", 0, 32'(pc_stall), 32'd1);
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk_all_zero("mid_stall_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
